// File: rtl/alarm_control_unit_if.sv
// -----------------------------------------------------------------------------
// alarm_control_unit_if
//
// Bundles every non-clock, non-reset signal of the alarm control core.
//
// Core inputs (driven by the keyboard / clock-counter side):
//   one_second   : one-clk pulse per second
//   key          : key code, valid for one clk per press (8'h00 = no key)
//   do_snooze    : one-clk pulse from the snooze button
//   stop_alarm   : one-clk pulse from the alarm-off button
//   current_time : BCD HHMM from the clock counter
// Core outputs:
//   key_buffer, load_new_time, load_alarm, show_keyboard, show_alarm,
//   alarm_time, display, sound_alarm, debug_state, debug_seconds,
//   debug_snooze, disp_state
//
// master : the side that drives the core inputs (keyboard / clock / bench)
// slave  : the alarm control core itself
// -----------------------------------------------------------------------------
interface alarm_control_unit_if;
   logic        one_second;
   logic [7:0]  key;
   logic        do_snooze;
   logic        stop_alarm;
   logic [15:0] current_time;

   logic [15:0] key_buffer;
   logic        load_new_time;
   logic        load_alarm;
   logic        show_keyboard;
   logic        show_alarm;
   logic [15:0] alarm_time;
   logic [15:0] display;
   logic        sound_alarm;
   logic [3:0]  debug_state;
   logic [7:0]  debug_seconds;
   logic [7:0]  debug_snooze;
   logic [2:0]  disp_state;

   modport master (
      output one_second, key, do_snooze, stop_alarm, current_time,
      input  key_buffer, load_new_time, load_alarm, show_keyboard, show_alarm,
             alarm_time, display, sound_alarm, debug_state, debug_seconds,
             debug_snooze, disp_state
   );

   modport slave (
      input  one_second, key, do_snooze, stop_alarm, current_time,
      output key_buffer, load_new_time, load_alarm, show_keyboard, show_alarm,
             alarm_time, display, sound_alarm, debug_state, debug_seconds,
             debug_snooze, disp_state
   );
endinterface

// File: rtl/alarm_control_unit.sv
// -----------------------------------------------------------------------------
// alarm_control_unit
//
// Alarm-clock control core. Three cooperating parts:
//   * keyboard-entry controller: shifts BCD digits into key_buffer and turns
//     'T' / 'A' into load pulses for the clock counter / alarm register, with
//     an inactivity timeout; an 'A' press in idle shows the alarm time.
//   * alarm-time register, loaded from key_buffer.
//   * alarm sequencer: rings when the running time steps onto the alarm time,
//     supports snooze (counted in minute changes of current_time) and stop.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : alarm_control_unit_if.slave carrying all other inputs/outputs
//
// Parameters:
//   ENTRY_TIMEOUT_S : seconds without a key before entry is abandoned
//   SHOW_ALARM_S    : seconds the alarm time is shown after 'A' in idle
//   SNOOZE_MINUTES  : current_time changes before a snoozed alarm re-rings
// -----------------------------------------------------------------------------
module alarm_control_unit #(
   parameter int ENTRY_TIMEOUT_S = 10,
   parameter int SHOW_ALARM_S    = 5,
   parameter int SNOOZE_MINUTES  = 10
) (
   input logic                  clk,
   input logic                  reset,
   alarm_control_unit_if.slave  bus
);

   localparam logic [7:0] ENTRY_LIMIT = 8'(ENTRY_TIMEOUT_S);
   localparam logic [7:0] SHOW_LIMIT  = 8'(SHOW_ALARM_S);
   localparam logic [7:0] SNOOZE_INIT = 8'(SNOOZE_MINUTES);

   localparam logic [7:0] KEY_A = 8'h41;
   localparam logic [7:0] KEY_T = 8'h54;

   typedef enum logic [1:0] {
      CTL_IDLE  = 2'd0,
      CTL_ENTRY = 2'd1,
      CTL_SHOW  = 2'd2
   } ctl_state_t;

   typedef enum logic [1:0] {
      SEQ_IDLE    = 2'd0,
      SEQ_RINGING = 2'd1,
      SEQ_SNOOZE  = 2'd2
   } seq_state_t;

   // ASCII '0'..'9'
   function automatic logic is_digit_key(input logic [7:0] k);
      return (k >= 8'h30) && (k <= 8'h39);
   endfunction

   // ---------------------------------------------------------------------------
   // Keyboard-entry controller
   // ---------------------------------------------------------------------------
   ctl_state_t  ctl_state;
   ctl_state_t  ctl_next;
   logic [7:0]  sec_cnt;
   logic [7:0]  sec_next;
   logic [15:0] key_buf;
   logic [15:0] key_buf_next;
   logic [15:0] alarm_reg;
   logic [15:0] alarm_next;
   logic        load_time_reg;
   logic        load_time_next;
   logic        load_alarm_reg;
   logic        load_alarm_next;

   logic        key_digit;
   logic        key_a;
   logic        key_t;
   logic [3:0]  digit;

   assign key_digit = is_digit_key(bus.key);
   assign key_a     = (bus.key == KEY_A);
   assign key_t     = (bus.key == KEY_T);
   assign digit     = bus.key[3:0];

   // Controller next-state, buffer shifting, timeout and load-pulse decode
   always_comb begin
      ctl_next        = ctl_state;
      sec_next        = sec_cnt;
      key_buf_next    = key_buf;
      alarm_next      = alarm_reg;
      load_time_next  = 1'b0;
      load_alarm_next = 1'b0;

      case (ctl_state)
         CTL_IDLE: begin
            sec_next = 8'd0;
            if (key_digit) begin
               key_buf_next = {12'h000, digit};
               ctl_next     = CTL_ENTRY;
            end else if (key_a) begin
               ctl_next = CTL_SHOW;
            end else begin
               ctl_next = CTL_IDLE;
            end
         end

         CTL_ENTRY: begin
            // A valid key always wins over a coincident one_second tick.
            if (key_digit) begin
               key_buf_next = {key_buf[11:0], digit};
               sec_next     = 8'd0;
            end else if (key_t) begin
               load_time_next = 1'b1;
               sec_next       = 8'd0;
               ctl_next       = CTL_IDLE;
            end else if (key_a) begin
               load_alarm_next = 1'b1;
               alarm_next      = key_buf;
               sec_next        = 8'd0;
               ctl_next        = CTL_IDLE;
            end else if (bus.one_second) begin
               if ((sec_cnt + 8'd1) >= ENTRY_LIMIT) begin
                  sec_next = 8'd0;
                  ctl_next = CTL_IDLE;
               end else begin
                  sec_next = sec_cnt + 8'd1;
               end
            end else begin
               sec_next = sec_cnt;
            end
         end

         CTL_SHOW: begin
            if (key_digit) begin
               key_buf_next = {12'h000, digit};
               sec_next     = 8'd0;
               ctl_next     = CTL_ENTRY;
            end else if (key_a || key_t) begin
               sec_next = 8'd0;
               ctl_next = CTL_IDLE;
            end else if (bus.one_second) begin
               if ((sec_cnt + 8'd1) >= SHOW_LIMIT) begin
                  sec_next = 8'd0;
                  ctl_next = CTL_IDLE;
               end else begin
                  sec_next = sec_cnt + 8'd1;
               end
            end else begin
               sec_next = sec_cnt;
            end
         end

         default: begin
            sec_next = 8'd0;
            ctl_next = CTL_IDLE;
         end
      endcase
   end

   // Controller state, buffers and load pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         ctl_state      <= CTL_IDLE;
         sec_cnt        <= 8'd0;
         key_buf        <= 16'h0000;
         alarm_reg      <= 16'h0000;
         load_time_reg  <= 1'b0;
         load_alarm_reg <= 1'b0;
      end else begin
         ctl_state      <= ctl_next;
         sec_cnt        <= sec_next;
         key_buf        <= key_buf_next;
         alarm_reg      <= alarm_next;
         load_time_reg  <= load_time_next;
         load_alarm_reg <= load_alarm_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Alarm sequencer
   // ---------------------------------------------------------------------------
   seq_state_t  seq_state;
   seq_state_t  seq_next;
   logic [7:0]  snooze_cnt;
   logic [7:0]  snooze_next;
   logic [15:0] prev_time;
   logic        time_changed;
   logic        trigger;

   // Only a step of the running clock onto the alarm time triggers; rewriting
   // the alarm register to the present time does not.
   assign time_changed = (bus.current_time != prev_time);
   assign trigger      = time_changed && (bus.current_time == alarm_reg);

   // Sequencer next-state and snooze countdown
   always_comb begin
      seq_next    = seq_state;
      snooze_next = snooze_cnt;

      case (seq_state)
         SEQ_IDLE: begin
            snooze_next = 8'd0;
            if (trigger) begin
               seq_next = SEQ_RINGING;
            end else begin
               seq_next = SEQ_IDLE;
            end
         end

         SEQ_RINGING: begin
            if (bus.stop_alarm) begin
               snooze_next = 8'd0;
               seq_next    = SEQ_IDLE;
            end else if (bus.do_snooze) begin
               snooze_next = SNOOZE_INIT;
               seq_next    = SEQ_SNOOZE;
            end else begin
               snooze_next = 8'd0;
               seq_next    = SEQ_RINGING;
            end
         end

         SEQ_SNOOZE: begin
            if (bus.stop_alarm) begin
               snooze_next = 8'd0;
               seq_next    = SEQ_IDLE;
            end else if (trigger) begin
               snooze_next = 8'd0;
               seq_next    = SEQ_RINGING;
            end else if (time_changed) begin
               // The change that would take the count to zero re-rings.
               if (snooze_cnt <= 8'd1) begin
                  snooze_next = 8'd0;
                  seq_next    = SEQ_RINGING;
               end else begin
                  snooze_next = snooze_cnt - 8'd1;
               end
            end else begin
               snooze_next = snooze_cnt;
            end
         end

         default: begin
            snooze_next = 8'd0;
            seq_next    = SEQ_IDLE;
         end
      endcase
   end

   // Sequencer state, snooze count and time-change history
   always_ff @(posedge clk) begin
      if (reset) begin
         seq_state  <= SEQ_IDLE;
         snooze_cnt <= 8'd0;
         prev_time  <= bus.current_time;
      end else begin
         seq_state  <= seq_next;
         snooze_cnt <= snooze_next;
         prev_time  <= bus.current_time;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.key_buffer    = key_buf;
   assign bus.load_new_time = load_time_reg;
   assign bus.load_alarm    = load_alarm_reg;
   assign bus.show_keyboard = (ctl_state == CTL_ENTRY);
   assign bus.show_alarm    = (ctl_state == CTL_SHOW);
   assign bus.alarm_time    = alarm_reg;
   assign bus.sound_alarm   = (seq_state == SEQ_RINGING);
   assign bus.debug_state   = {2'b00, ctl_state};
   assign bus.debug_seconds = sec_cnt;
   assign bus.debug_snooze  = snooze_cnt;
   assign bus.disp_state    = {1'b0, seq_state};

   // Display source follows the controller mode.
   assign bus.display = bus.show_keyboard ? key_buf :
                        bus.show_alarm    ? alarm_reg :
                                            bus.current_time;

endmodule

// File: tb/tb_alarm_control_unit.sv
// -----------------------------------------------------------------------------
// tb_alarm_control_unit
//
// Directed stimulus for alarm_control_unit. Expected responses are queued by
// the stimulus process; an independent monitor on the falling clock edge pops
// and compares whenever the DUT presents an event (load pulse, controller
// state change, sound_alarm change) or when a snapshot probe is raised.
// -----------------------------------------------------------------------------
module tb_alarm_control_unit;

   logic clk;
   logic reset;
   logic probe;
   logic mon_en;

   int checks;
   int failures;

   alarm_control_unit_if bus ();

   alarm_control_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [79:0] val;
   } exp_t;

   exp_t        q_probe[$];
   logic [15:0] q_lt[$];
   logic [15:0] q_la[$];
   logic [3:0]  q_ctl[$];
   logic        q_ring[$];

   function automatic void check(input string name, input logic [79:0] act,
                                 input logic [79:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endfunction

   function automatic void unexpected(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=event required=none", name);
   endfunction

   // Monitor: pops expectations as the DUT presents events
   logic [3:0] prev_dbg;
   logic       prev_snd;
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.load_new_time === 1'b1) begin
            if (q_lt.size() == 0) unexpected("load_new_time_pulse");
            else check("load_new_time_key_buffer", {64'h0, bus.key_buffer},
                       {64'h0, q_lt.pop_front()});
         end
         if (bus.load_alarm === 1'b1) begin
            if (q_la.size() == 0) unexpected("load_alarm_pulse");
            else check("load_alarm_alarm_time", {64'h0, bus.alarm_time},
                       {64'h0, q_la.pop_front()});
         end
         if (bus.debug_state !== prev_dbg) begin
            if (q_ctl.size() == 0) unexpected("debug_state_change");
            else check("debug_state_change", {76'h0, bus.debug_state},
                       {76'h0, q_ctl.pop_front()});
         end
         if (bus.sound_alarm !== prev_snd) begin
            if (q_ring.size() == 0) unexpected("sound_alarm_change");
            else check("sound_alarm_change", {79'h0, bus.sound_alarm},
                       {79'h0, q_ring.pop_front()});
         end
         if (probe === 1'b1) begin
            if (q_probe.size() == 0) unexpected("probe_without_expectation");
            else begin
               exp_t e;
               e = q_probe.pop_front();
               check(e.name,
                     {4'h0, bus.key_buffer, bus.alarm_time, bus.display,
                      bus.debug_snooze, bus.debug_seconds, bus.sound_alarm,
                      bus.disp_state, bus.debug_state, bus.show_keyboard,
                      bus.show_alarm, bus.load_new_time, bus.load_alarm},
                     e.val);
            end
         end
      end
      prev_dbg = bus.debug_state;
      prev_snd = bus.sound_alarm;
   end

   // One clock with the given pulses, then pulses return to idle.
   task automatic step(input logic [7:0] k, input logic os, input logic sn,
                       input logic st);
      bus.key        = k;
      bus.one_second = os;
      bus.do_snooze  = sn;
      bus.stop_alarm = st;
      @(posedge clk);
      #1;
      bus.key        = 8'h00;
      bus.one_second = 1'b0;
      bus.do_snooze  = 1'b0;
      bus.stop_alarm = 1'b0;
   endtask

   task automatic key(input logic [7:0] k);
      step(k, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick_time(input logic [15:0] t);
      bus.current_time = t;
      step(8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   // Snapshot expectation; show flags follow the controller state code.
   task automatic expect_state(input string name, input logic [15:0] kb,
                               input logic [15:0] at, input logic [15:0] disp,
                               input logic [7:0] snz, input logic [7:0] sec,
                               input logic snd, input logic [2:0] ds,
                               input logic [3:0] dbg, input logic lt,
                               input logic la);
      exp_t e;
      e.name = name;
      e.val  = {4'h0, kb, at, disp, snz, sec, snd, ds, dbg,
                (dbg == 4'd1), (dbg == 4'd2), lt, la};
      q_probe.push_back(e);
      probe = 1'b1;
      @(negedge clk);
      #1;
      probe = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks           = 0;
      failures         = 0;
      probe            = 1'b0;
      mon_en           = 1'b0;
      reset            = 1'b1;
      bus.key          = 8'h00;
      bus.one_second   = 1'b0;
      bus.do_snooze    = 1'b0;
      bus.stop_alarm   = 1'b0;
      bus.current_time = 16'h1200;

      for (int i = 0; i < 3; i++) key(8'h00);
      reset  = 1'b0;
      mon_en = 1'b1;
      expect_state("reset_state", 16'h0000, 16'h0000, 16'h1200, 8'd0, 8'd0,
                   1'b0, 3'd0, 4'd0, 1'b0, 1'b0);

      // 'T' and buttons in idle do nothing
      key(8'h54);
      step(8'h00, 1'b0, 1'b1, 1'b1);
      expect_state("idle_ignores_t_and_buttons", 16'h0000, 16'h0000, 16'h1200,
                   8'd0, 8'd0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);

      // Set time 12:30
      q_ctl.push_back(4'd1);
      key(8'h31);
      expect_state("entry_first_digit", 16'h0001, 16'h0000, 16'h0001, 8'd0,
                   8'd0, 1'b0, 3'd0, 4'd1, 1'b0, 1'b0);
      key(8'h32);
      key(8'h33);
      key(8'h30);
      expect_state("entry_four_digits", 16'h1230, 16'h0000, 16'h1230, 8'd0,
                   8'd0, 1'b0, 3'd0, 4'd1, 1'b0, 1'b0);
      q_lt.push_back(16'h1230);
      q_ctl.push_back(4'd0);
      key(8'h54);
      expect_state("load_new_time_cycle", 16'h1230, 16'h0000, 16'h1200, 8'd0,
                   8'd0, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0);
      key(8'h00);
      expect_state("load_new_time_one_clk", 16'h1230, 16'h0000, 16'h1200,
                   8'd0, 8'd0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);

      // Set alarm 07:00
      q_ctl.push_back(4'd1);
      key(8'h30);
      key(8'h37);
      key(8'h30);
      key(8'h30);
      q_la.push_back(16'h0700);
      q_ctl.push_back(4'd0);
      key(8'h41);
      expect_state("load_alarm_cycle", 16'h0700, 16'h0700, 16'h1200, 8'd0,
                   8'd0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1);

      // Show alarm, times out after five seconds
      q_ctl.push_back(4'd2);
      key(8'h41);
      expect_state("show_alarm_entered", 16'h0700, 16'h0700, 16'h0700, 8'd0,
                   8'd0, 1'b0, 3'd0, 4'd2, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(8'h00, 1'b1, 1'b0, 1'b0);
      expect_state("show_alarm_four_seconds", 16'h0700, 16'h0700, 16'h0700,
                   8'd0, 8'd4, 1'b0, 3'd0, 4'd2, 1'b0, 1'b0);
      q_ctl.push_back(4'd0);
      step(8'h00, 1'b1, 1'b0, 1'b0);
      expect_state("show_alarm_timeout", 16'h0700, 16'h0700, 16'h1200, 8'd0,
                   8'd0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);

      // Key coinciding with one_second clears the counter
      q_ctl.push_back(4'd1);
      key(8'h35);
      for (int i = 0; i < 3; i++) step(8'h00, 1'b1, 1'b0, 1'b0);
      step(8'h36, 1'b1, 1'b0, 1'b0);
      expect_state("key_beats_second", 16'h0056, 16'h0700, 16'h0056, 8'd0,
                   8'd0, 1'b0, 3'd0, 4'd1, 1'b0, 1'b0);
      q_lt.push_back(16'h0056);
      q_ctl.push_back(4'd0);
      key(8'h54);

      // Entry timeout after ten silent seconds, no load
      q_ctl.push_back(4'd1);
      key(8'h35);
      for (int i = 0; i < 9; i++) step(8'h00, 1'b1, 1'b0, 1'b0);
      expect_state("entry_nine_seconds", 16'h0005, 16'h0700, 16'h0005, 8'd0,
                   8'd9, 1'b0, 3'd0, 4'd1, 1'b0, 1'b0);
      q_ctl.push_back(4'd0);
      step(8'h00, 1'b1, 1'b0, 1'b0);
      expect_state("entry_timeout", 16'h0005, 16'h0700, 16'h1200, 8'd0, 8'd0,
                   1'b0, 3'd0, 4'd0, 1'b0, 1'b0);

      // Alarm rings on 06:59 -> 07:00, stop, no re-ring while time holds
      tick_time(16'h0659);
      q_ring.push_back(1'b1);
      tick_time(16'h0700);
      expect_state("alarm_ringing", 16'h0005, 16'h0700, 16'h0700, 8'd0, 8'd0,
                   1'b1, 3'd1, 4'd0, 1'b0, 1'b0);
      q_ring.push_back(1'b0);
      step(8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) key(8'h00);
      expect_state("stopped_no_rering", 16'h0005, 16'h0700, 16'h0700, 8'd0,
                   8'd0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);

      // Snooze: ten minute changes re-ring; stop beats snooze
      tick_time(16'h0659);
      q_ring.push_back(1'b1);
      tick_time(16'h0700);
      q_ring.push_back(1'b0);
      step(8'h00, 1'b0, 1'b1, 1'b0);
      expect_state("snooze_loaded", 16'h0005, 16'h0700, 16'h0700, 8'd10, 8'd0,
                   1'b0, 3'd2, 4'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 9; i++) tick_time(16'h0700 + 16'(i));
      expect_state("snooze_nine_changes", 16'h0005, 16'h0700, 16'h0709, 8'd1,
                   8'd0, 1'b0, 3'd2, 4'd0, 1'b0, 1'b0);
      q_ring.push_back(1'b1);
      tick_time(16'h0710);
      expect_state("snooze_rering", 16'h0005, 16'h0700, 16'h0710, 8'd0, 8'd0,
                   1'b1, 3'd1, 4'd0, 1'b0, 1'b0);
      q_ring.push_back(1'b0);
      step(8'h00, 1'b0, 1'b1, 1'b1);
      expect_state("stop_beats_snooze", 16'h0005, 16'h0700, 16'h0710, 8'd0,
                   8'd0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);

      // Stop during snooze clears the count
      tick_time(16'h0659);
      q_ring.push_back(1'b1);
      tick_time(16'h0700);
      q_ring.push_back(1'b0);
      step(8'h00, 1'b0, 1'b1, 1'b0);
      tick_time(16'h0701);
      tick_time(16'h0702);
      expect_state("snooze_two_changes", 16'h0005, 16'h0700, 16'h0702, 8'd8,
                   8'd0, 1'b0, 3'd2, 4'd0, 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b0, 1'b1);
      expect_state("stop_in_snooze", 16'h0005, 16'h0700, 16'h0702, 8'd0, 8'd0,
                   1'b0, 3'd0, 4'd0, 1'b0, 1'b0);

      // Reset while ringing and mid-entry
      tick_time(16'h0659);
      q_ring.push_back(1'b1);
      tick_time(16'h0700);
      q_ctl.push_back(4'd1);
      key(8'h31);
      expect_state("ringing_during_entry", 16'h0001, 16'h0700, 16'h0001, 8'd0,
                   8'd0, 1'b1, 3'd1, 4'd1, 1'b0, 1'b0);
      q_ring.push_back(1'b0);
      q_ctl.push_back(4'd0);
      reset = 1'b1;
      key(8'h00);
      reset = 1'b0;
      expect_state("reset_mid_ring", 16'h0000, 16'h0000, 16'h0700, 8'd0, 8'd0,
                   1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
      key(8'h00);
      key(8'h00);
      expect_state("after_reset_quiet", 16'h0000, 16'h0000, 16'h0700, 8'd0,
                   8'd0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);

      // Every queued event must have been observed
      check("pending_load_new_time", 80'(q_lt.size()), 80'd0);
      check("pending_load_alarm", 80'(q_la.size()), 80'd0);
      check("pending_state_change", 80'(q_ctl.size()), 80'd0);
      check("pending_sound_change", 80'(q_ring.size()), 80'd0);
      check("pending_probe", 80'(q_probe.size()), 80'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alarm_control_unit.md
Name: alarm_control_unit

Overview:
Alarm-clock control core. It combines three functions:
- a keyboard-entry controller (digit buffer plus set-time/set-alarm commands with timeout);
- the alarm-time register;
- the display driver / alarm sequencer (ring, snooze, stop).

It sits between the keyboard interface and the clock counter / 7-segment driver. It consumes one-second pulses and the current BCD time (HHMM, 16 bits).

Parameters:
ENTRY_TIMEOUT_S, 10, seconds without a key before entry mode is abandoned
SHOW_ALARM_S, 5, seconds the alarm time is shown after an 'A' press in idle
SNOOZE_MINUTES, 10, minute changes of current_time before a snoozed alarm re-rings

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high
one_second  in  1  one-clk pulse, once per second
key  in  8  key code, valid for one clk per press; 8'h00 = no key
do_snooze  in  1  one-clk pulse, snooze button
stop_alarm  in  1  one-clk pulse, alarm-off button
current_time  in  16  BCD HHMM from the clock counter
key_buffer  out  16  BCD digits entered
load_new_time  out  1  one-clk pulse: clock counter loads key_buffer
load_alarm  out  1  one-clk pulse: alarm register loads key_buffer
show_keyboard  out  1  high in ENTRY
show_alarm  out  1  high in SHOW_ALARM
alarm_time  out  16  stored alarm time
display  out  16  word for the 7-seg driver
sound_alarm  out  1  high while ringing
debug_state  out  4  controller state code
debug_seconds  out  8  controller seconds counter
debug_snooze  out  8  snooze minutes remaining
disp_state  out  3  alarm sequencer state code

Behaviour:
- Reset: all outputs 0; both FSMs in IDLE; alarm_time = 16'h0000; match history prev_time = current_time.
- Key codes:
  - 8'h30–8'h39 are digits 0–9.
  - 8'h41 'A' means show alarm / set alarm.
  - 8'h54 'T' means set time.
  - All other codes are ignored.
- Controller states: IDLE=0, ENTRY=1, SHOW_ALARM=2.
  - IDLE + digit d: key_buffer <= {12'h000, d}, go to ENTRY, seconds counter <= 0.
  - IDLE + 'A': go to SHOW_ALARM, seconds counter <= 0.
  - IDLE + 'T': ignored.
  - ENTRY + digit d: key_buffer <= {key_buffer[11:0], d}; seconds counter <= 0.
  - ENTRY + 'T': load_new_time pulses high for exactly one clk; go to IDLE.
  - ENTRY + 'A': load_alarm pulses for one clk; alarm_time <= key_buffer on that same edge; go to IDLE.
  - SHOW_ALARM + digit: behaves as IDLE + digit.
  - SHOW_ALARM + any other valid key: go to IDLE.
- Seconds counter:
  - Increments on one_second in ENTRY and SHOW_ALARM.
  - Reaching ENTRY_TIMEOUT_S (ENTRY) or SHOW_ALARM_S (SHOW_ALARM) returns to IDLE without any load.
  - A key arriving in the same cycle as one_second takes priority; the counter clears.
- No range validation of entered digits.
- key_buffer holds its value after leaving ENTRY.
- Outputs:
  - show_keyboard = (state==ENTRY); show_alarm = (state==SHOW_ALARM).
  - debug_state = state; debug_seconds = counter.
- display (combinational): key_buffer if show_keyboard, else alarm_time if show_alarm, else current_time.
- Alarm sequencer states: IDLE=0, RINGING=1, SNOOZE=2; sound_alarm = (state==RINGING).
- Trigger: prev_time register updates every clk. A trigger occurs only in the cycle where current_time != prev_time and current_time == alarm_time. Changing alarm_time alone never triggers, and neither does reset.
- IDLE + trigger: go to RINGING.
- RINGING:
  - stop_alarm: go to IDLE.
  - else do_snooze: snooze count <= SNOOZE_MINUTES; go to SNOOZE.
  - stop_alarm has priority over a simultaneous do_snooze.
  - A further trigger is ignored.
- SNOOZE:
  - Each current_time change decrements the snooze count.
  - When the count reaches 0, go to RINGING.
  - stop_alarm: go to IDLE, count cleared.
  - do_snooze: ignored.
  - A trigger re-rings immediately.
- do_snooze and stop_alarm in IDLE: no effect.
- disp_state = state; debug_snooze = snooze count (0 outside SNOOZE).
- Reset mid-ring or mid-entry: silent, IDLE, buffers cleared, no load pulses.

Test Plan:
- Keys 31,32,33,30,54 -> key_buffer 16'h1230; show_keyboard high during entry; load_new_time high exactly 1 clk; display then returns to current_time.
- Keys 30,37,30,30,41 -> alarm_time 16'h0700 on the load_alarm clk. Then key 41 -> show_alarm = 1 and display = 16'h0700, back to IDLE after 5 one_second pulses.
- Key 35 then 10 one_second pulses with no key -> IDLE with no load pulses; key_buffer stays 16'h0005.
- alarm_time = 0700, current_time 0659 -> 0700 -> sound_alarm high next clk. stop_alarm -> low. Time stays 0700 -> no re-ring.
- Ringing, do_snooze -> debug_snooze = 10. After 10 current_time changes -> sound_alarm high again. do_snooze+stop_alarm in the same clk -> IDLE.
- Reset asserted while ringing -> sound_alarm 0, alarm_time 0000, disp_state 0, debug_state 0.
